// File: rtl/cmd_pkg.sv
// Command parser shared definitions: host command codes, error codes and
// the parser state encoding.
package cmd_pkg;

  localparam logic [7:0] CMD_SEND   = 8'h01;
  localparam logic [7:0] CMD_CHANGE = 8'h02;
  localparam logic [7:0] CMD_RESET  = 8'hA5;

  localparam logic [1:0] ERR_UNKNOWN  = 2'd0;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd1;
  localparam logic [1:0] ERR_OVERRUN  = 2'd2;
  localparam logic [1:0] ERR_BAD_IDX  = 2'd3;  // bad index or bad checksum

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ID,
    ST_CHECK,
    ST_APPLY,
    ST_SEND_WAIT
  } state_e;

endpackage

// File: rtl/byte_timeout.sv
// Inter-byte timeout counter.
//   clk, rst_n : clock, async active-low reset
//   en         : count only while high; held at zero otherwise
//   restart    : a byte was accepted, start counting again from zero
//   expired    : counter has reached TIMEOUT_CYCLES-1 (saturates there)
module byte_timeout #(
  parameter int TIMEOUT_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic restart,
  output logic expired
);
  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CW-1:0] cnt;

  assign expired = en && (cnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)               cnt <= '0;
    else if (!en || restart)  cnt <= '0;
    else if (!expired)        cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/cmd_rx_parser.sv
// Byte-stream host command parser feeding the redstone core.
// Decodes SEND_OUTPUTS (0x01), CHANGE_INPUT (0x02 + ID bytes) and RESET (0xA5),
// owns the registered input vector, and handshakes send requests with the
// output serialiser. Optional macro CMD_CHECKSUM_EN adds a trailing XOR
// checksum byte to CHANGE_INPUT.
// Ports:
//   i_clk, i_rst          : clock, async active-low reset
//   i_rx_data, i_rx_valid : received byte + one-cycle strobe
//   i_send_ack            : serialiser accepts the send request
//   o_inputs              : input vector to the redstone core
//   o_send_req            : held from 0x01 decode until i_send_ack
//   o_soft_rst            : one-cycle pulse on 0xA5
//   o_err, o_err_code     : error pulse; code held until the next error
//   o_busy                : parser not in IDLE
module cmd_rx_parser
  import cmd_pkg::*;
#(
  parameter int NUM_INPUTS     = 8,
  parameter int ID_BYTES       = 2,
  parameter int TIMEOUT_CYCLES = 500000
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [7:0]            i_rx_data,
  input  logic                  i_rx_valid,
  input  logic                  i_send_ack,
  output logic [NUM_INPUTS-1:0] o_inputs,
  output logic                  o_send_req,
  output logic                  o_soft_rst,
  output logic                  o_err,
  output logic [1:0]            o_err_code,
  output logic                  o_busy
);
  localparam int AW = ID_BYTES * 8;

  state_e                state, state_n;
  logic [AW-1:0]         acc, acc_n;
  logic [2:0]            bcnt, bcnt_n;
  logic [7:0]            csum, csum_n;
  logic [NUM_INPUTS-1:0] inputs_n;
  logic                  req_n, soft_n, err_n;
  logic [1:0]            code_n;
  logic                  expired;

  logic [AW-2:0] idx;
  logic          idx_ok;
  assign idx    = acc[AW-1:1];
  assign idx_ok = 32'(idx) < NUM_INPUTS;

  byte_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_tmo (
    .clk     (i_clk),
    .rst_n   (i_rst),
    .en      (state == ST_ID || state == ST_CHECK),
    .restart (i_rx_valid),
    .expired (expired)
  );

  always_comb begin
    state_n  = state;
    acc_n    = acc;
    bcnt_n   = bcnt;
    csum_n   = csum;
    inputs_n = o_inputs;
    req_n    = o_send_req;
    soft_n   = 1'b0;
    err_n    = 1'b0;
    code_n   = o_err_code;
    case (state)
      ST_IDLE: if (i_rx_valid) begin
        case (i_rx_data)
          CMD_SEND: begin
            req_n   = 1'b1;
            state_n = ST_SEND_WAIT;
          end
          CMD_CHANGE: begin
            acc_n   = '0;
            bcnt_n  = 3'(ID_BYTES);
            csum_n  = CMD_CHANGE;
            state_n = ST_ID;
          end
          CMD_RESET: begin
            inputs_n = '0;
            soft_n   = 1'b1;
          end
          default: begin
            err_n  = 1'b1;
            code_n = ERR_UNKNOWN;
          end
        endcase
      end
      ST_ID: begin
        // An arriving byte wins over a coincident timeout.
        if (i_rx_valid) begin
          acc_n  = AW'({acc, i_rx_data});
          csum_n = csum ^ i_rx_data;
          bcnt_n = bcnt - 3'd1;
          if (bcnt == 3'd1) begin
`ifdef CMD_CHECKSUM_EN
            state_n = ST_CHECK;
`else
            state_n = ST_APPLY;
`endif
          end
        end else if (expired) begin
          err_n   = 1'b1;
          code_n  = ERR_TIMEOUT;
          state_n = ST_IDLE;
        end
      end
      ST_CHECK: begin
        if (i_rx_valid) begin
          if (i_rx_data == csum) begin
            state_n = ST_APPLY;
          end else begin
            err_n   = 1'b1;
            code_n  = ERR_BAD_IDX;
            state_n = ST_IDLE;
          end
        end else if (expired) begin
          err_n   = 1'b1;
          code_n  = ERR_TIMEOUT;
          state_n = ST_IDLE;
        end
      end
      ST_APPLY: begin
        if (i_rx_valid) begin
          err_n  = 1'b1;
          code_n = ERR_OVERRUN;
        end
        // A bad index outranks a coincident overrun in the reported code.
        if (idx_ok) begin
          for (int i = 0; i < NUM_INPUTS; i++)
            if (idx == (AW-1)'(i)) inputs_n[i] = acc[0];
        end else begin
          err_n  = 1'b1;
          code_n = ERR_BAD_IDX;
        end
        state_n = ST_IDLE;
      end
      ST_SEND_WAIT: begin
        if (i_rx_valid) begin
          err_n  = 1'b1;
          code_n = ERR_OVERRUN;
        end
        if (i_send_ack) begin
          req_n   = 1'b0;
          state_n = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state      <= ST_IDLE;
      acc        <= '0;
      bcnt       <= '0;
      csum       <= '0;
      o_inputs   <= '0;
      o_send_req <= 1'b0;
      o_soft_rst <= 1'b0;
      o_err      <= 1'b0;
      o_err_code <= ERR_UNKNOWN;
      o_busy     <= 1'b0;
    end else begin
      state      <= state_n;
      acc        <= acc_n;
      bcnt       <= bcnt_n;
      csum       <= csum_n;
      o_inputs   <= inputs_n;
      o_send_req <= req_n;
      o_soft_rst <= soft_n;
      o_err      <= err_n;
      o_err_code <= code_n;
      o_busy     <= (state_n != ST_IDLE);
    end
  end

endmodule
